// File: rtl/serial_to_parallel_frame.sv
// serial_to_parallel_frame
// Gathers signed samples, one per accepted cycle, into a depth-entry frame and
// presents the completed frame on a registered parallel array guarded by a
// frame_valid/out_ack handshake. Index 0 holds the first sample received, which
// matches the transmit-side unloader that emits index 0 first.

module serial_to_parallel_frame #(
  parameter  int reg_width = 32,
  parameter  int depth     = 10,
  localparam int CNT_W     = $clog2(depth)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        flush,
  input  logic                        in_valid,
  input  logic signed [reg_width-1:0] serial_data,
  input  logic                        out_ack,
  output logic signed [reg_width-1:0] parallel_data [depth-1:0],
  output logic                        frame_valid,
  output logic [CNT_W-1:0]            fill_level,
  output logic                        overflow
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(depth - 1);

  logic signed [reg_width-1:0] coll [depth-1:0];

  logic acc;
  logic frame_done;
  logic frame_load;

  // Flush wins over a sample presented in the same cycle. A completed frame
  // may only replace the presented one if the slot is empty or being
  // acknowledged right now; otherwise it is dropped.
  always_comb begin
    acc        = en && in_valid && !flush;
    frame_done = acc && (fill_level == LAST_IDX);
    frame_load = frame_done && (!frame_valid || out_ack);
  end

  // Collection buffer: each accepted sample is written at the current fill
  // position. The final slot is never read back here because the last sample
  // bypasses straight into the output frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        coll[i] <= '0;
      end
    end else if (acc) begin
      coll[fill_level] <= serial_data;
    end
  end

  // Fill counter: advances per accepted sample and wraps once the frame is
  // complete, whether that frame was presented or dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fill_level <= '0;
    end else if (flush) begin
      fill_level <= '0;
    end else if (acc) begin
      if (fill_level == LAST_IDX) begin
        fill_level <= '0;
      end else begin
        fill_level <= fill_level + CNT_W'(1);
      end
    end
  end

  // Output frame register: loads the gathered samples plus the same-cycle
  // final sample, so a frame is visible the cycle after its last sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < depth; i++) begin
        parallel_data[i] <= '0;
      end
    end else if (frame_load) begin
      for (int i = 0; i < depth - 1; i++) begin
        parallel_data[i] <= coll[i];
      end
      parallel_data[depth-1] <= serial_data;
    end
  end

  // Handshake flag: set on a frame load, cleared by an acknowledge that is
  // not simultaneously replaced by a new frame. Flush and en do not touch it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_valid <= 1'b0;
    end else if (frame_load) begin
      frame_valid <= 1'b1;
    end else if (out_ack) begin
      frame_valid <= 1'b0;
    end
  end

  // Sticky drop indicator: set when a completed frame could not be presented,
  // cleared only by flush (or reset).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (frame_done && !frame_load) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_to_parallel_frame.sv
// tb_serial_to_parallel_frame
// Directed bench for serial_to_parallel_frame with depth = 8 and 32-bit
// samples. Expected values are written out by hand next to each step.

module tb_serial_to_parallel_frame;

  localparam int W = 32;
  localparam int D = 8;

  logic                clk;
  logic                rst;
  logic                en;
  logic                flush;
  logic                in_valid;
  logic signed [W-1:0] serial_data;
  logic                out_ack;
  logic signed [W-1:0] parallel_data [D-1:0];
  logic                frame_valid;
  logic [2:0]          fill_level;
  logic                overflow;

  int vectors;
  int miscompares;

  serial_to_parallel_frame #(
    .reg_width (W),
    .depth     (D)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .flush         (flush),
    .in_valid      (in_valid),
    .serial_data   (serial_data),
    .out_ack       (out_ack),
    .parallel_data (parallel_data),
    .frame_valid   (frame_valid),
    .fill_level    (fill_level),
    .overflow      (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every vector, reports any miscompare.
  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, lets the rising edge take them, and returns
  // 1 time unit after the edge so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic v, input logic e, input logic f,
                               input logic a, input int d);
    in_valid    = v;
    en          = e;
    flush       = f;
    out_ack     = a;
    serial_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkFrame(input string tag, input int expv [0:7]);
    for (int i = 0; i < D; i++) begin
      checkOutput($sformatf("%s[%0d]", tag, i), parallel_data[i], expv[i]);
    end
  endtask

  task automatic idle(input logic a);
    applyStimulus(1'b0, 1'b1, 1'b0, a, 0);
  endtask

  int exp_a   [0:7];
  int exp_b   [0:7];
  int zeros   [0:7];
  int tx_vals [0:7];
  int sh      [0:7];

  initial begin
    int k;
    int c;
    logic v;
    logic e;

    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    en          = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    out_ack     = 1'b0;
    serial_data = '0;
    zeros       = '{0, 0, 0, 0, 0, 0, 0, 0};

    // Reset state
    #3;
    checkOutput("rst_frame_valid", frame_valid, 0);
    checkOutput("rst_fill_level", fill_level, 0);
    checkOutput("rst_overflow", overflow, 0);
    checkFrame("rst_pd", zeros);
    #9;
    rst = 1'b1;

    // Basic frame 60..130, no acknowledge
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 60 + 10 * i);
      if (i == 2) checkOutput("basic_fill_3", fill_level, 3);
      if (i == 6) checkOutput("basic_fv_before_last", frame_valid, 0);
    end
    exp_a = '{60, 70, 80, 90, 100, 110, 120, 130};
    checkOutput("basic_frame_valid", frame_valid, 1);
    checkFrame("basic_pd", exp_a);
    checkOutput("basic_fill_wrap", fill_level, 0);
    checkOutput("basic_overflow", overflow, 0);

    // Back-pressure: second frame 200..207 dropped
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 200 + i);
    end
    checkOutput("bp_overflow", overflow, 1);
    checkOutput("bp_frame_valid", frame_valid, 1);
    checkFrame("bp_pd_held", exp_a);
    checkOutput("bp_fill_wrap", fill_level, 0);
    idle(1'b1);
    checkOutput("bp_ack_clears_fv", frame_valid, 0);
    checkOutput("bp_overflow_sticky", overflow, 1);
    idle(1'b1);
    checkOutput("ack_idle_ignored", frame_valid, 0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("bp_flush_clears_ovf", overflow, 0);

    // Simultaneous ack with the last sample of the next frame
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 300 + i);
    end
    checkOutput("sim_first_fv", frame_valid, 1);
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, (i == D - 1), 400 + i);
    end
    exp_b = '{400, 401, 402, 403, 404, 405, 406, 407};
    checkOutput("sim_fv_stays", frame_valid, 1);
    checkFrame("sim_pd", exp_b);
    checkOutput("sim_overflow", overflow, 0);
    idle(1'b1);
    checkOutput("sim_ack_clears", frame_valid, 0);

    // Loopback from a load-then-shift transmitter model, index 0 first
    tx_vals = '{-5, 7, -9, 11, -13, 15, -17, 19};
    sh      = tx_vals;
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, sh[0]);
      for (int j = 0; j < D - 1; j++) sh[j] = sh[j+1];
      sh[D-1] = 0;
    end
    checkOutput("loop_fv", frame_valid, 1);
    checkFrame("loop_pd", tx_vals);
    idle(1'b1);

    // Gapped input: in_valid toggles, en low for cycles 5..7
    k = 0;
    c = 0;
    while (k < D && c < 40) begin
      v = (c % 2 == 0);
      e = !(c >= 5 && c <= 7);
      applyStimulus(v, e, 1'b0, 1'b0, (v && e) ? 1000 + k : 9999);
      if (v && e) k++;
      if (c == 6) checkOutput("gap_fill_hold_en", fill_level, 3);
      if (c == 7) checkOutput("gap_fill_hold_inv", fill_level, 3);
      if (k < D) checkOutput($sformatf("gap_fv_c%0d", c), frame_valid, 0);
      c++;
    end
    checkOutput("gap_cycles", c, 17);
    exp_b = '{1000, 1001, 1002, 1003, 1004, 1005, 1006, 1007};
    checkOutput("gap_fv", frame_valid, 1);
    checkFrame("gap_pd", exp_b);
    idle(1'b1);

    // Flush abort: 5 samples, then flush with a 6th sample
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 500 + i);
    end
    checkOutput("abort_fill_5", fill_level, 5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 777);
    checkOutput("abort_fill_0", fill_level, 0);
    checkOutput("abort_fv", frame_valid, 0);
    for (int i = 0; i < D; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 600 + i);
    end
    exp_b = '{600, 601, 602, 603, 604, 605, 606, 607};
    checkOutput("clean_fv", frame_valid, 1);
    checkFrame("clean_pd", exp_b);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("flush_keeps_fv", frame_valid, 1);
    checkOutput("flush_keeps_pd0", parallel_data[0], 600);

    // Asynchronous reset mid-frame with a frame still presented
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 700 + i);
    end
    checkOutput("pre_rst_fill", fill_level, 3);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("arst_fill", fill_level, 0);
    checkOutput("arst_fv", frame_valid, 0);
    checkOutput("arst_ovf", overflow, 0);
    checkFrame("arst_pd", zeros);
    #10;
    rst = 1'b1;

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/serial_to_parallel_frame.md
Name: serial_to_parallel_frame

Overview:
- Receive-side counterpart of the transmit parallel-to-serial unloader.
- Collects a stream of signed samples, one per valid cycle, into a DEPTH-entry frame and presents the frame on a parallel array with a valid/ack handshake.
- Sample order is preserved: the first sample received lands in index 0, matching the transmit side, which emits index 0 first.
- Sits between the serial sample stream (e.g. CP-removal output) and frame-based blocks such as the FFT input buffer.

Parameters:
- reg_width, 32, bit width of each signed sample.
- depth, 10, samples per frame (>=2).
- CNT_W, $clog2(depth), width of the fill counter (localparam).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  collection enable; when low, incoming samples are ignored and the fill count is frozen.
- flush  input  1  synchronous abort of the partial frame; also clears overflow.
- in_valid  input  1  serial_data is valid this cycle.
- serial_data  input  signed reg_width  incoming sample.
- out_ack  input  1  consumer accepts the presented frame.
- parallel_data  output  signed reg_width x [depth-1:0]  presented frame (registered).
- frame_valid  output  1  parallel_data holds an unconsumed frame.
- fill_level  output  CNT_W  samples collected in the current partial frame.
- overflow  output  1  sticky: a completed frame was dropped.

Behaviour:
- Reset (rst low, async): all parallel_data entries = 0, collection buffer = 0, fill_level = 0, frame_valid = 0, overflow = 0. Reset mid-frame discards the partial frame; no output event.
- Accept condition: acc = en && in_valid && !flush. On acc, coll[fill_level] <= serial_data.
- fill_level < depth-1 on acc: fill_level increments by 1.
- fill_level == depth-1 on acc (frame complete): fill_level <= 0 (wrap).
  - If !frame_valid || out_ack: parallel_data[i] <= coll[i] for i < depth-1, and parallel_data[depth-1] <= serial_data (same-cycle bypass). frame_valid <= 1. Latency: frame visible the cycle after the last sample's edge.
  - Otherwise (previous frame unacknowledged): the new frame is dropped, parallel_data is unchanged, and overflow <= 1.
- Handshake:
  - frame_valid stays high and parallel_data stays stable until out_ack is sampled high while frame_valid = 1.
  - out_ack with no frame completing that cycle: frame_valid <= 0.
  - out_ack in the same cycle a frame completes: the new frame loads and frame_valid stays 1 (back-to-back, no bubble).
  - out_ack while frame_valid = 0: ignored.
- out_ack is honoured regardless of en and flush.
- flush:
  - fill_level <= 0 and overflow <= 0.
  - A sample presented in the same cycle is discarded.
  - parallel_data and frame_valid are unaffected, so a presented frame survives flush.
- en low: in_valid/serial_data are ignored, fill_level and coll are held, and the output side operates normally.
- No arithmetic: samples are copied bit-exact and sign is preserved.
- Stale coll entries from an earlier frame are always overwritten before the next load, because every frame is fully written before completion.

Test Plan:
- depth=8. Reset, then en=1 and 8 consecutive valid samples 60,70,...,130 with out_ack=0 -> cycle after 8th sample: frame_valid=1, parallel_data[0]=60 ... [7]=130, fill_level=0, overflow=0.
- Loopback: the transmit parallel-to-serial unit loaded with {-5,7,-9,11,-13,15,-17,19} (load then 7 shifts), its serial output fed into this block with in_valid aligned -> recovered frame identical and index-ordered, including negative values.
- Gapped input: 8 samples with in_valid toggling 1,0,1,0 and en dropped for 3 cycles mid-frame -> fill_level holds during the gaps, the frame completes only after the 8th accepted sample, contents are correct.
- Back-pressure: first frame held (out_ack=0), second full frame of 200..207 arrives -> overflow=1, parallel_data still 60..130. Then out_ack pulse -> frame_valid=0 next cycle. Then flush -> overflow=0.
- Simultaneous: out_ack asserted in the same cycle as the 8th sample of frame 2 -> frame_valid stays 1, parallel_data = frame 2, overflow stays 0.
- Abort cases:
  - 5 samples, then flush together with a 6th sample -> fill_level=0, sample dropped; the next 8 samples form a clean frame.
  - rst asserted after 3 samples -> all outputs 0 immediately (async).
